// File: rtl/vp_pkg.sv
// Shared constants, types and helpers for the synthetic video pattern source.
// Defaults describe 1280x720 raster timing; the top level can override them.
package vp_pkg;

    localparam int PIX_W = 24;
    localparam int CNT_W = 12;

    localparam int H_ACT_720  = 1280;
    localparam int H_FP_720   = 110;
    localparam int H_SYNC_720 = 40;
    localparam int H_BP_720   = 220;
    localparam int V_ACT_720  = 720;
    localparam int V_FP_720   = 5;
    localparam int V_SYNC_720 = 5;
    localparam int V_BP_720   = 20;

    typedef enum logic [1:0] {
        PAT_BARS  = 2'd0,
        PAT_CHECK = 2'd1,
        PAT_BOX   = 2'd2,
        PAT_GRAD  = 2'd3
    } pat_t;

    typedef enum logic {
        DIR_FWD = 1'b0,
        DIR_REV = 1'b1
    } dir_t;

    typedef struct packed {
        logic [CNT_W-1:0] pos;
        dir_t             dir;
    } box_axis_t;

    localparam logic [PIX_W-1:0] COL_WHITE   = 24'hFFFFFF;
    localparam logic [PIX_W-1:0] COL_YELLOW  = 24'hFFFF00;
    localparam logic [PIX_W-1:0] COL_CYAN    = 24'h00FFFF;
    localparam logic [PIX_W-1:0] COL_GREEN   = 24'h00FF00;
    localparam logic [PIX_W-1:0] COL_MAGENTA = 24'hFF00FF;
    localparam logic [PIX_W-1:0] COL_RED     = 24'hFF0000;
    localparam logic [PIX_W-1:0] COL_BLUE    = 24'h0000FF;
    localparam logic [PIX_W-1:0] COL_BLACK   = 24'h000000;
    localparam logic [PIX_W-1:0] COL_BOX_BG  = 24'h000040;

    function automatic logic [PIX_W-1:0] bar_colour(input logic [2:0] idx);
        logic [PIX_W-1:0] col;
        case (idx)
            3'd0:    col = COL_WHITE;
            3'd1:    col = COL_YELLOW;
            3'd2:    col = COL_CYAN;
            3'd3:    col = COL_GREEN;
            3'd4:    col = COL_MAGENTA;
            3'd5:    col = COL_RED;
            3'd6:    col = COL_BLUE;
            default: col = COL_BLACK;
        endcase
        return col;
    endfunction

    // Smallest x whose bar index x*8/act reaches k; constant-folds to a compare threshold.
    function automatic logic [CNT_W-1:0] bar_bound(input int k, input int act);
        return CNT_W'((k * act + 7) / 8);
    endfunction

    function automatic box_axis_t box_step(input box_axis_t    cur,
                                           input logic [CNT_W-1:0] lim,
                                           input logic [CNT_W-1:0] step);
        box_axis_t  nxt;
        logic [CNT_W:0] fwd;
        nxt = cur;
        fwd = {1'b0, cur.pos} + {1'b0, step};
        if (cur.dir == DIR_FWD) begin
            if (fwd > {1'b0, lim}) begin
                nxt.pos = lim;
                nxt.dir = DIR_REV;
            end else begin
                nxt.pos = fwd[CNT_W-1:0];
            end
        end else begin
            if (cur.pos < step) begin
                nxt.pos = '0;
                nxt.dir = DIR_FWD;
            end else begin
                nxt.pos = cur.pos - step;
            end
        end
        return nxt;
    endfunction

endpackage

// File: rtl/vp_timing_gen.sv
// Raster counters with combinational de/sync/frame-start decode of the current position.
// Line and frame order: active, front porch, sync, back porch.
module vp_timing_gen
    import vp_pkg::*;
#(
    parameter int H_ACT  = H_ACT_720,
    parameter int H_FP   = H_FP_720,
    parameter int H_SYNC = H_SYNC_720,
    parameter int H_BP   = H_BP_720,
    parameter int V_ACT  = V_ACT_720,
    parameter int V_FP   = V_FP_720,
    parameter int V_SYNC = V_SYNC_720,
    parameter int V_BP   = V_BP_720
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [CNT_W-1:0] h_cnt,
    output logic [CNT_W-1:0] v_cnt,
    output logic             de,
    output logic             h_sync,
    output logic             v_sync,
    output logic             first_pix,
    output logic             blank_start
);

    localparam int H_TOT = H_ACT + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACT + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOT - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOT - 1);
    localparam logic [CNT_W-1:0] H_ACT_C  = CNT_W'(H_ACT);
    localparam logic [CNT_W-1:0] V_ACT_C  = CNT_W'(V_ACT);
    localparam logic [CNT_W-1:0] HS_BEGIN = CNT_W'(H_ACT + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACT + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_BEGIN = CNT_W'(V_ACT + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACT + V_FP + V_SYNC);

    // Disabling parks the raster at the origin so re-enable always starts a fresh frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (!en) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    always_comb begin
        de          = (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);
        h_sync      = (h_cnt >= HS_BEGIN) && (h_cnt < HS_END);
        v_sync      = (v_cnt >= VS_BEGIN) && (v_cnt < VS_END);
        first_pix   = (h_cnt == '0) && (v_cnt == '0);
        blank_start = (h_cnt == '0) && (v_cnt == V_ACT_C);
    end

endmodule

// File: rtl/vp_pattern_gen.sv
// Synthetic video source: raster timing plus one of four test patterns, all outputs
// registered one clock after the counters they describe.
module vp_pattern_gen
    import vp_pkg::*;
#(
    parameter int   H_ACT    = H_ACT_720,
    parameter int   H_FP     = H_FP_720,
    parameter int   H_SYNC   = H_SYNC_720,
    parameter int   H_BP     = H_BP_720,
    parameter int   V_ACT    = V_ACT_720,
    parameter int   V_FP     = V_FP_720,
    parameter int   V_SYNC   = V_SYNC_720,
    parameter int   V_BP     = V_BP_720,
    parameter logic SYNC_POL = 1'b1,
    parameter int   BOX_SIZE = 64,
    parameter int   BOX_STEP = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       pat_sel,
    output logic [PIX_W-1:0] pixel_out,
    output logic             v_sync_out,
    output logic             h_sync_out,
    output logic             de_out,
    output logic             frame_start
);

    localparam logic [CNT_W-1:0] BX_MAX   = CNT_W'(H_ACT - BOX_SIZE);
    localparam logic [CNT_W-1:0] BY_MAX   = CNT_W'(V_ACT - BOX_SIZE);
    localparam logic [CNT_W-1:0] BOX_SZ   = CNT_W'(BOX_SIZE);
    localparam logic [CNT_W-1:0] BOX_STP  = CNT_W'(BOX_STEP);

    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic             tg_de;
    logic             tg_h_sync;
    logic             tg_v_sync;
    logic             tg_first;
    logic             tg_blank_start;

    pat_t             pat_q;
    pat_t             pat_now;
    logic [7:0]       frame_cnt;
    box_axis_t        box_x;
    box_axis_t        box_y;
    box_axis_t        box_x_nxt;
    box_axis_t        box_y_nxt;
    logic [2:0]       bar_idx;
    logic             in_box;
    logic [PIX_W-1:0] pat_pix;

    vp_timing_gen #(
        .H_ACT  (H_ACT),
        .H_FP   (H_FP),
        .H_SYNC (H_SYNC),
        .H_BP   (H_BP),
        .V_ACT  (V_ACT),
        .V_FP   (V_FP),
        .V_SYNC (V_SYNC),
        .V_BP   (V_BP)
    ) u_timing (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .h_cnt       (h_cnt),
        .v_cnt       (v_cnt),
        .de          (tg_de),
        .h_sync      (tg_h_sync),
        .v_sync      (tg_v_sync),
        .first_pix   (tg_first),
        .blank_start (tg_blank_start)
    );

    // The origin pixel already uses the newly sampled pattern, so every frame is uniform.
    assign pat_now = tg_first ? pat_t'(pat_sel) : pat_q;

    always_comb begin
        bar_idx = '0;
        for (int k = 1; k < 8; k++) begin
            if (h_cnt >= bar_bound(k, H_ACT)) begin
                bar_idx = bar_idx + 3'd1;
            end
        end
    end

    assign in_box = (h_cnt >= box_x.pos) && (h_cnt < box_x.pos + BOX_SZ) &&
                    (v_cnt >= box_y.pos) && (v_cnt < box_y.pos + BOX_SZ);

    always_comb begin
        pat_pix = COL_BLACK;
        case (pat_now)
            PAT_BARS:  pat_pix = bar_colour(bar_idx);
            PAT_CHECK: pat_pix = (h_cnt[5] ^ v_cnt[5]) ? COL_WHITE : COL_BLACK;
            PAT_BOX:   pat_pix = in_box ? COL_WHITE : COL_BOX_BG;
            PAT_GRAD:  pat_pix = {h_cnt[7:0], v_cnt[7:0], frame_cnt};
            default:   pat_pix = COL_BLACK;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat_q     <= PAT_BARS;
            frame_cnt <= '0;
        end else if (en && tg_first) begin
            pat_q     <= pat_t'(pat_sel);
            frame_cnt <= frame_cnt + 8'd1;
        end
    end

    assign box_x_nxt = box_step(box_x, BX_MAX, BOX_STP);
    assign box_y_nxt = box_step(box_y, BY_MAX, BOX_STP);

    // Box bounces once per frame on the first blanking line, never while visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            box_x <= '{pos: '0, dir: DIR_FWD};
            box_y <= '{pos: '0, dir: DIR_FWD};
        end else if (en && tg_blank_start) begin
            box_x <= box_x_nxt;
            box_y <= box_y_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pixel_out   <= '0;
            de_out      <= 1'b0;
            h_sync_out  <= ~SYNC_POL;
            v_sync_out  <= ~SYNC_POL;
            frame_start <= 1'b0;
        end else if (!en) begin
            pixel_out   <= '0;
            de_out      <= 1'b0;
            h_sync_out  <= ~SYNC_POL;
            v_sync_out  <= ~SYNC_POL;
            frame_start <= 1'b0;
        end else begin
            pixel_out   <= tg_de ? pat_pix : '0;
            de_out      <= tg_de;
            h_sync_out  <= tg_h_sync ? SYNC_POL : ~SYNC_POL;
            v_sync_out  <= tg_v_sync ? SYNC_POL : ~SYNC_POL;
            frame_start <= tg_first;
        end
    end

endmodule

// File: tb/tb_vp_pattern_gen.sv
// Randomised bench for vp_pattern_gen on a reduced raster, compared cycle by cycle
// against a frame-position reference model.
module tb_vp_pattern_gen;

    localparam int   H_ACT    = 16;
    localparam int   H_FP     = 2;
    localparam int   H_SYNC   = 3;
    localparam int   H_BP     = 3;
    localparam int   V_ACT    = 8;
    localparam int   V_FP     = 1;
    localparam int   V_SYNC   = 2;
    localparam int   V_BP     = 1;
    localparam int   H_TOT    = H_ACT + H_FP + H_SYNC + H_BP;
    localparam int   V_TOT    = V_ACT + V_FP + V_SYNC + V_BP;
    localparam int   FRAME    = H_TOT * V_TOT;
    localparam int   BOX_SIZE = 4;
    localparam int   BOX_STEP = 4;
    localparam logic SYNC_POL = 1'b1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [1:0]  pat_sel = 2'd0;
    logic [23:0] pixel_out;
    logic        v_sync_out;
    logic        h_sync_out;
    logic        de_out;
    logic        frame_start;

    vp_pattern_gen #(
        .H_ACT    (H_ACT),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACT    (V_ACT),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .SYNC_POL (SYNC_POL),
        .BOX_SIZE (BOX_SIZE),
        .BOX_STEP (BOX_STEP)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .pat_sel     (pat_sel),
        .pixel_out   (pixel_out),
        .v_sync_out  (v_sync_out),
        .h_sync_out  (h_sync_out),
        .de_out      (de_out),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    int m_pos;
    int m_fc;
    int m_pat;
    int m_bx;
    int m_by;
    int m_dx;
    int m_dy;

    logic [23:0] exp_pix;
    logic        exp_de;
    logic        exp_hs;
    logic        exp_vs;
    logic        exp_fs;

    logic [23:0] bar_tab [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                 24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    task automatic checkOutput(input string tag, input logic [23:0] got, input logic [23:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%h exp=%h pos=%0d t=%0t", tag, got, exp, m_pos, $time);
        end
    endtask

    task automatic applyStimulus(input logic en_v, input logic [1:0] pat_v);
        en      = en_v;
        pat_sel = pat_v;
    endtask

    task automatic modelReset();
        m_pos = 0;
        m_fc  = 0;
        m_pat = 0;
        m_bx  = 0;
        m_by  = 0;
        m_dx  = 1;
        m_dy  = 1;
    endtask

    task automatic setIdle();
        exp_pix = 24'h0;
        exp_de  = 1'b0;
        exp_hs  = ~SYNC_POL;
        exp_vs  = ~SYNC_POL;
        exp_fs  = 1'b0;
    endtask

    task automatic moveAxis(inout int pos, inout int dir, input int lim);
        int nxt;
        nxt = pos + dir * BOX_STEP;
        if (nxt > lim) begin
            pos = lim;
            dir = -dir;
        end else if (nxt < 0) begin
            pos = 0;
            dir = -dir;
        end else begin
            pos = nxt;
        end
    endtask

    function automatic logic [23:0] modelPixel(input int pat, input int x, input int y);
        logic [23:0] p;
        case (pat)
            0: p = bar_tab[x * 8 / H_ACT];
            1: p = (((x / 32) % 2) != ((y / 32) % 2)) ? 24'hFFFFFF : 24'h000000;
            2: p = (x >= m_bx && x < m_bx + BOX_SIZE && y >= m_by && y < m_by + BOX_SIZE)
                   ? 24'hFFFFFF : 24'h000040;
            default: p = {8'(x), 8'(y), 8'(m_fc)};
        endcase
        return p;
    endfunction

    task automatic modelStep();
        int x;
        int y;
        int pat;
        if (!rst_n) begin
            modelReset();
            setIdle();
        end else if (!en) begin
            m_pos = 0;
            setIdle();
        end else begin
            x   = m_pos % H_TOT;
            y   = m_pos / H_TOT;
            pat = (m_pos == 0) ? int'(pat_sel) : m_pat;
            exp_de  = (x < H_ACT) && (y < V_ACT);
            exp_pix = exp_de ? modelPixel(pat, x, y) : 24'h0;
            exp_hs  = (x >= H_ACT + H_FP && x < H_ACT + H_FP + H_SYNC) ? SYNC_POL : ~SYNC_POL;
            exp_vs  = (y >= V_ACT + V_FP && y < V_ACT + V_FP + V_SYNC) ? SYNC_POL : ~SYNC_POL;
            exp_fs  = (m_pos == 0);
            if (m_pos == 0) begin
                m_pat = pat;
                m_fc  = (m_fc + 1) % 256;
            end
            if (m_pos == V_ACT * H_TOT) begin
                moveAxis(m_bx, m_dx, H_ACT - BOX_SIZE);
                moveAxis(m_by, m_dy, V_ACT - BOX_SIZE);
            end
            m_pos = (m_pos + 1) % FRAME;
        end
    endtask

    task automatic checkAll();
        checkOutput("pixel_out",   pixel_out,          exp_pix);
        checkOutput("de_out",      24'(de_out),        24'(exp_de));
        checkOutput("h_sync_out",  24'(h_sync_out),    24'(exp_hs));
        checkOutput("v_sync_out",  24'(v_sync_out),    24'(exp_vs));
        checkOutput("frame_start", 24'(frame_start),   24'(exp_fs));
    endtask

    task automatic tick();
        @(posedge clk);
        modelStep();
        #1;
        checkAll();
    endtask

    initial begin
        int budget;
        modelReset();
        setIdle();
        repeat (3) tick();

        $display("[TB] reset release with bars");
        applyStimulus(1'b1, 2'd0);
        rst_n = 1'b1;
        repeat (2 * FRAME) tick();

        $display("[TB] mid-frame switch bars -> gradient");
        repeat (FRAME / 2 + 7) tick();
        applyStimulus(1'b1, 2'd3);
        repeat (FRAME + FRAME / 2) tick();

        $display("[TB] moving box");
        applyStimulus(1'b1, 2'd2);
        repeat (7 * FRAME) tick();

        $display("[TB] enable dropout mid-line");
        repeat ($urandom_range(H_TOT + 3, FRAME / 2)) tick();
        applyStimulus(1'b0, 2'd2);
        repeat (10) tick();
        applyStimulus(1'b1, 2'd2);
        repeat (2 * FRAME) tick();

        $display("[TB] random pattern and enable traffic");
        for (int i = 0; i < 12; i++) begin
            applyStimulus(($urandom_range(0, 7) != 0), 2'($urandom_range(0, 3)));
            repeat ($urandom_range(5, 150)) tick();
        end

        $display("[TB] asynchronous reset mid-active, then frame counter wrap");
        applyStimulus(1'b1, 2'd3);
        budget = 2 * FRAME;
        while (m_pos != 3 * H_TOT + 6 && budget > 0) begin
            tick();
            budget--;
        end
        checkOutput("reach_mid_active", 24'(budget > 0), 24'd1);
        checkOutput("de_before_reset", 24'(de_out), 24'd1);
        #2;
        rst_n = 1'b0;
        #1;
        modelReset();
        setIdle();
        checkAll();
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (256 * FRAME + 3 * H_TOT) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
